// File: rtl/stack_unit_pkg.sv
// Shared definitions for the operand stack.
// Holds the default word width and depth, the occupancy-width helper, and
// the {push,pop} operation encoding.
// No ports.
package stack_unit_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

  // Operation decoded from {push, pop}.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array backing the operand stack.
// The array has one synchronous write port and one asynchronous read port.
// It has no reset; stale contents are never observable through the stack.
// Ports:
//   clk    in  : write clock
//   we     in  : write enable
//   waddr  in  : write address
//   wdata  in  : write data
//   raddr  in  : read address
//   rdata  out : read data (combinational)
module stack_ram
  import stack_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [cnt_w(DEPTH)-2:0]     waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [cnt_w(DEPTH)-2:0]     raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack driven by the StackMIPS controller's Push/Pop/ToS strobes.
// Ports:
//   clk        in  : clock, all state changes on posedge
//   rst        in  : asynchronous active-high reset
//   push       in  : push strobe (with pop: replace top)
//   pop        in  : pop strobe
//   tos        in  : capture the pre-edge top of stack into dout
//   din        in  : word to push
//   dout       out : registered top-of-stack word
//   count      out : occupancy 0..DEPTH
//   empty      out : count == 0 (combinational)
//   full       out : count == DEPTH (combinational)
//   overflow   out : sticky, push attempted while full
//   underflow  out : sticky, pop or tos attempted while empty
// Build option: define STACK_GUARD_EN to enable the sticky overflow and
// underflow flags. Without it, both flags are tied low and
// count saturation and write suppression behave the same.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  op_e              op;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [WIDTH-1:0] rdata;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign top_addr = AW'(count - CW'(1));
  assign op       = op_e'({push, pop});

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_addr),
    .rdata (rdata)
  );

  // Op decode: the read of the top happens before this edge's write, so
  // tos with pop/push/replace always returns the old top.
  always_comb begin
    count_nxt = count;
    dout_nxt  = dout;
    we        = 1'b0;
    waddr     = AW'(count);
    if (tos) dout_nxt = empty ? '0 : rdata;
    case (op)
      OP_POP: begin
        if (!empty) count_nxt = count - CW'(1);
      end
      OP_PUSH: begin
        if (!full) begin
          we        = 1'b1;
          count_nxt = count + CW'(1);
        end
      end
      OP_REPL: begin
        // Replace on an empty stack degenerates to a plain push into slot 0.
        we = 1'b1;
        if (empty) count_nxt = CW'(1);
        else       waddr     = top_addr;
      end
      default: ;
    endcase
  end

  // Occupancy and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dout  <= '0;
    end else begin
      count <= count_nxt;
      dout  <= dout_nxt;
    end
  end

`ifdef STACK_GUARD_EN
  logic ovf_set;
  logic unf_set;

  // Push+pop while full is a replace, not an overflow; push+pop while
  // empty is a push, not an underflow.
  assign ovf_set = (op == OP_PUSH) && full;
  assign unf_set = empty && (tos || (op == OP_POP));

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a queue-based reference model is
// compared against the DUT on every falling edge, and directed sequences add
// hand-computed literal checks.
// Ports: none.
module tb_stack_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             tos = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_tests = 0;
  int n_fail  = 0;

  stack_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .din       (din),
    .dout      (dout),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf  = 1'b0;
  bit               m_unf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      automatic bit e = (q.size() == 0);
      automatic bit f = (q.size() == DEPTH);
      if (tos) m_dout = e ? '0 : q[q.size()-1];
      if (e && (tos || (pop && !push))) m_unf = 1'b1;
      if (push && pop) begin
        if (e) q.push_back(din);
        else   q[q.size()-1] = din;
      end else if (push) begin
        if (f) m_ovf = 1'b1;
        else   q.push_back(din);
      end else if (pop) begin
        if (!e) void'(q.pop_back());
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_count", int'(count), q.size());
      chk("model_dout", int'(dout), int'(m_dout));
      chk("model_empty", int'(empty), int'(q.size() == 0));
      chk("model_full", int'(full), int'(q.size() == DEPTH));
      chk("model_overflow", int'(overflow), GUARD ? int'(m_ovf) : 0);
      chk("model_underflow", int'(underflow), GUARD ? int'(m_unf) : 0);
    end
  end

  // One clocked operation; outputs are settled when it returns.
  task automatic step(input bit p, input bit o, input bit t, input logic [WIDTH-1:0] d);
    push = p;
    pop  = o;
    tos  = t;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);

    // Three pushes, then tos returns the last one.
    @(negedge clk);
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(0, 0, 1, 8'h00);
    chk("t2_dout", int'(dout), 'h33);
    chk("t2_count", int'(count), 3);

    // Asynchronous reset mid-cycle with count=3 and dout nonzero.
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_count", int'(count), 0);
    chk("t1_rst_dout", int'(dout), 0);
    chk("t1_rst_empty", int'(empty), 1);
    chk("t1_rst_ovf", int'(overflow), 0);
    chk("t1_rst_unf", int'(underflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Rebuild, then tos+pop returns the popped word.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(0, 1, 1, 8'h00);
    chk("t3_dout", int'(dout), 'h33);
    chk("t3_count", int'(count), 2);
    step(0, 0, 1, 8'h00);
    chk("t3_dout_next", int'(dout), 'h22);

    // Replace top, with tos+push returning the old top.
    step(1, 1, 1, 8'h5A);
    chk("t6_count", int'(count), 2);
    chk("t6_dout_old_top", int'(dout), 'h22);
    step(0, 0, 1, 8'h00);
    chk("t6_dout", int'(dout), 'h5A);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("t6_below", int'(dout), 'h11);

    // Fill to DEPTH, then a push while full is suppressed.
    step(0, 1, 0, 8'h00);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, WIDTH'(i));
    chk("t4_full", int'(full), 1);
    step(1, 0, 0, 8'hFF);
    chk("t4_count", int'(count), 8);
    chk("t4_ovf", int'(overflow), int'(GUARD));
    step(0, 0, 1, 8'h00);
    chk("t4_top", int'(dout), 'h08);
    step(1, 1, 0, 8'hAB);
    step(0, 0, 1, 8'h00);
    chk("t4_repl_full", int'(dout), 'hAB);
    chk("t4_repl_count", int'(count), 8);

    // Drain past empty, then tos on the empty stack clears dout.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
    chk("t5_empty", int'(empty), 1);
    chk("t5_unf_before", int'(underflow), 0);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("t5_count", int'(count), 0);
    chk("t5_dout", int'(dout), 0);
    chk("t5_unf", int'(underflow), int'(GUARD));

    // Push+pop on an empty stack acts as a push.
    step(1, 1, 0, 8'hC3);
    chk("repl_empty_count", int'(count), 1);
    step(0, 0, 1, 8'h00);
    chk("repl_empty_dout", int'(dout), 'hC3);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
